// File: rtl/vx_exec_packet_arbiter.sv
// Execute-port arbiter: shares one FU port among NUM_REQS dispatch blocks.
// Round-robin at instruction granularity. A granted sop locks the port to that
// requester until its eop fires. A credit counter bounds instructions in flight.
module vx_exec_packet_arbiter #(
   parameter int unsigned NUM_REQS    = 4,
   parameter int unsigned DATAW       = 64,
   parameter int unsigned MAX_CREDITS = 4,
   parameter int unsigned SEL_W       = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
   parameter int unsigned CRD_W       = $clog2(MAX_CREDITS + 1)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQS-1:0]       req_valid,
   input  logic [NUM_REQS*DATAW-1:0] req_data,
   input  logic [NUM_REQS-1:0]       req_sop,
   input  logic [NUM_REQS-1:0]       req_eop,
   output logic [NUM_REQS-1:0]       req_ready,
   output logic                      out_valid,
   output logic [DATAW-1:0]          out_data,
   output logic                      out_sop,
   output logic                      out_eop,
   output logic [SEL_W-1:0]          out_sel,
   input  logic                      out_ready,
   input  logic                      credit_return,
   output logic [CRD_W-1:0]          credits_avail
);

   typedef enum logic {StIdle, StLocked} state_e;

   state_e           state_q, state_d;
   logic [SEL_W-1:0] lock_idx_q, lock_idx_d;
   logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [CRD_W-1:0] credits_q, credits_d;

   logic [NUM_REQS-1:0] eligible;
   logic                any_elig;
   logic [SEL_W-1:0]    winner;
   logic [SEL_W-1:0]    sel;
   logic                sel_valid;
   logic                sel_sop;
   logic                sel_eop;
   logic [DATAW-1:0]    sel_data;
   logic                fire;
   logic                cred_take;
   logic                cred_zero;
   logic                cred_full;

   assign eligible  = req_valid & req_sop;
   assign cred_zero = (credits_q == '0);
   assign cred_full = (credits_q == CRD_W'(MAX_CREDITS));

   // Round-robin winner: eligible index with the smallest distance from rr_ptr.
   always_comb begin
      int unsigned best_off;
      int unsigned off;
      winner   = '0;
      any_elig = 1'b0;
      best_off = NUM_REQS;
      off      = 0;
      for (int unsigned j = 0; j < NUM_REQS; j++) begin
         off = (j + NUM_REQS - 32'(rr_ptr_q)) % NUM_REQS;
         if (eligible[j] && (off < best_off)) begin
            best_off = off;
            winner   = SEL_W'(j);
            any_elig = 1'b1;
         end
      end
   end

   // Source mux: the lock owner while locked, otherwise the round-robin winner.
   always_comb begin
      sel       = (state_q == StLocked) ? lock_idx_q : winner;
      sel_valid = 1'b0;
      sel_sop   = 1'b0;
      sel_eop   = 1'b0;
      sel_data  = '0;
      for (int unsigned j = 0; j < NUM_REQS; j++) begin
         if (SEL_W'(j) == sel) begin
            sel_valid = req_valid[j];
            sel_sop   = req_sop[j];
            sel_eop   = req_eop[j];
            sel_data  = req_data[j*DATAW +: DATAW];
         end
      end
   end

   // Output decode; credit gate applies only when starting a new instruction.
   always_comb begin
      out_sel       = sel;
      out_data      = sel_data;
      out_sop       = sel_sop;
      out_eop       = sel_eop;
      credits_avail = credits_q;
      req_ready     = '0;
      if (state_q == StLocked) begin
         out_valid = sel_valid;
      end else begin
         out_valid = any_elig && !cred_zero;
      end
      for (int unsigned j = 0; j < NUM_REQS; j++) begin
         if ((SEL_W'(j) == sel) && ((state_q == StLocked) || out_valid)) begin
            req_ready[j] = out_ready;
         end
      end
   end

   assign fire      = out_valid && out_ready;
   // Guard against underflow should a protocol-violating sop fire while locked.
   assign cred_take = fire && out_sop && !cred_zero;

   // Next-state: lock tracking, round-robin pointer advance and credit count.
   always_comb begin
      state_d    = state_q;
      lock_idx_d = lock_idx_q;
      rr_ptr_d   = rr_ptr_q;
      credits_d  = credits_q;
      if (fire) begin
         unique case (state_q)
            StIdle: begin
               if (!out_eop) begin
                  state_d    = StLocked;
                  lock_idx_d = winner;
               end
            end
            StLocked: begin
               if (out_eop) begin
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
         if (out_eop) begin
            rr_ptr_d = (out_sel == SEL_W'(NUM_REQS - 1)) ? '0 : out_sel + SEL_W'(1);
         end
      end
      unique case ({cred_take, credit_return})
         2'b10:   credits_d = credits_q - CRD_W'(1);
         2'b01:   credits_d = cred_full ? credits_q : credits_q + CRD_W'(1);
         default: credits_d = credits_q;
      endcase
   end

   // State register with synchronous active-high reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         lock_idx_q <= '0;
         rr_ptr_q   <= '0;
         credits_q  <= CRD_W'(MAX_CREDITS);
      end else begin
         state_q    <= state_d;
         lock_idx_q <= lock_idx_d;
         rr_ptr_q   <= rr_ptr_d;
         credits_q  <= credits_d;
      end
   end

   // Protocol checks.
   a_credit_overflow: assert property (@(posedge clk) disable iff (reset)
      !(credit_return && !cred_take && cred_full))
      else $error("credit_return with all credits already available");

   a_idle_non_sop: assert property (@(posedge clk) disable iff (reset)
      (state_q == StIdle) |-> ((req_valid & ~req_sop) == '0))
      else $error("non-sop beat presented while no instruction is in progress");

   a_locked_sop: assert property (@(posedge clk) disable iff (reset)
      (state_q == StLocked) |-> !(sel_valid && sel_sop))
      else $error("sop beat from lock owner before its eop");

   a_valid_stable: assert property (@(posedge clk) disable iff (reset)
      (out_valid && !out_ready) |=> out_valid)
      else $error("out_valid dropped under backpressure");

endmodule

// File: tb/tb_vx_exec_packet_arbiter.sv
// Self-checking bench for vx_exec_packet_arbiter: directed scenarios plus a
// randomized run against an instruction-level reference model.
module tb_vx_exec_packet_arbiter;

   localparam int N   = 4;
   localparam int DW  = 64;
   localparam int MC  = 4;
   localparam int MCB = 2;
   localparam int SW  = 2;
   localparam int CW  = 3;
   localparam int CWB = 2;

   logic            clk;
   logic            reset;
   logic [N-1:0]    req_valid, req_sop, req_eop, req_ready;
   logic [N*DW-1:0] req_data;
   logic            out_valid, out_sop, out_eop, out_ready, credit_return;
   logic [DW-1:0]   out_data;
   logic [SW-1:0]   out_sel;
   logic [CW-1:0]   credits_avail;

   logic [N-1:0]    b_req_valid, b_req_sop, b_req_eop, b_req_ready;
   logic [N*DW-1:0] b_req_data;
   logic            b_out_valid, b_out_sop, b_out_eop, b_out_ready, b_credit_return;
   logic [DW-1:0]   b_out_data;
   logic [SW-1:0]   b_out_sel;
   logic [CWB-1:0]  b_credits_avail;

   int total;
   int bad;

   wire [11:0] snap   = {out_valid, out_sel, req_ready, out_sop, out_eop, credits_avail};
   wire [7:0]  snap_s = {out_valid, req_ready, credits_avail};
   wire [6:0]  b_snap = {b_out_valid, b_req_ready, b_credits_avail};

   vx_exec_packet_arbiter #(.NUM_REQS(N), .DATAW(DW), .MAX_CREDITS(MC)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_data(req_data), .req_sop(req_sop), .req_eop(req_eop),
      .req_ready(req_ready),
      .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
      .out_sel(out_sel), .out_ready(out_ready),
      .credit_return(credit_return), .credits_avail(credits_avail)
   );

   vx_exec_packet_arbiter #(.NUM_REQS(N), .DATAW(DW), .MAX_CREDITS(MCB)) dut_b (
      .clk(clk), .reset(reset),
      .req_valid(b_req_valid), .req_data(b_req_data), .req_sop(b_req_sop),
      .req_eop(b_req_eop), .req_ready(b_req_ready),
      .out_valid(b_out_valid), .out_data(b_out_data), .out_sop(b_out_sop),
      .out_eop(b_out_eop), .out_sel(b_out_sel), .out_ready(b_out_ready),
      .credit_return(b_credit_return), .credits_avail(b_credits_avail)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic set_req(input int i, input logic v, input logic s, input logic e,
                          input logic [DW-1:0] d);
      req_valid[i] = v;
      req_sop[i]   = s;
      req_eop[i]   = e;
      req_data[i*DW +: DW] = d;
   endtask

   task automatic clear_reqs();
      req_valid = '0;
      req_sop   = '0;
      req_eop   = '0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      clear_reqs();
      req_data = '0;
      out_ready = 1'b0;
      credit_return = 1'b0;
      b_req_valid = '0; b_req_sop = '0; b_req_eop = '0; b_req_data = '0;
      b_out_ready = 1'b0; b_credit_return = 1'b0;
      step(); step();
      #1;
      total++;
      if (snap_s !== {1'b0, 4'b0000, 3'd4}) begin
         bad++; $display("FAIL reset_state got %h want %h", snap_s, {1'b0, 4'b0000, 3'd4});
      end
      total++;
      if (b_snap !== {1'b0, 4'b0000, 2'd2}) begin
         bad++; $display("FAIL reset_state_b got %h want %h", b_snap, {1'b0, 4'b0000, 2'd2});
      end
      // Outputs are combinational: a request is visible even while in reset.
      set_req(2, 1'b1, 1'b1, 1'b1, 64'h2);
      out_ready = 1'b1;
      #1;
      total++;
      if ({out_valid, out_sel, req_ready} !== {1'b1, 2'd2, 4'b0100}) begin
         bad++; $display("FAIL reset_comb got %h want %h", {out_valid, out_sel, req_ready},
                         {1'b1, 2'd2, 4'b0100});
      end
      step();
      clear_reqs();
      reset = 1'b0;
      #1;
      total++;
      if (snap_s !== {1'b0, 4'b0000, 3'd4}) begin
         bad++; $display("FAIL reset_release got %h want %h", snap_s, {1'b0, 4'b0000, 3'd4});
      end
   endtask

   task automatic test_contention();
      logic [11:0] exp;
      step();
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b1, 1'b1, 64'hA0 + 64'(i));
      out_ready = 1'b1;
      credit_return = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         exp = {1'b1, 2'(c % 4), 4'(1 << (c % 4)), 1'b1, 1'b1, 3'd4};
         total++;
         if (snap !== exp || out_data !== 64'hA0 + 64'(c % 4)) begin
            bad++; $display("FAIL contention[%0d] got %h/%h want %h/%h", c, snap, out_data,
                            exp, 64'hA0 + 64'(c % 4));
         end
         step();
      end
      clear_reqs();
      credit_return = 1'b0;
   endtask

   task automatic test_lock();
      // rr_ptr is 1 here, so req1 wins over req2.
      set_req(1, 1'b1, 1'b1, 1'b0, 64'hB1);
      set_req(2, 1'b1, 1'b1, 1'b1, 64'hC2);
      #1;
      total++;
      if (snap !== {1'b1, 2'd1, 4'b0010, 1'b1, 1'b0, 3'd4} || out_data !== 64'hB1) begin
         bad++; $display("FAIL lock_beat1 got %h want %h", snap, {1'b1, 2'd1, 4'b0010, 5'b10100});
      end
      step();
      set_req(1, 1'b1, 1'b0, 1'b0, 64'hB2);
      #1;
      total++;
      if (snap !== {1'b1, 2'd1, 4'b0010, 1'b0, 1'b0, 3'd3} || out_data !== 64'hB2) begin
         bad++; $display("FAIL lock_beat2 got %h want %h", snap, {1'b1, 2'd1, 4'b0010, 5'b00011});
      end
      step();
      set_req(1, 1'b1, 1'b0, 1'b1, 64'hB3);
      #1;
      total++;
      if (snap !== {1'b1, 2'd1, 4'b0010, 1'b0, 1'b1, 3'd3} || out_data !== 64'hB3) begin
         bad++; $display("FAIL lock_beat3 got %h want %h", snap, {1'b1, 2'd1, 4'b0010, 5'b01011});
      end
      step();
      set_req(1, 1'b0, 1'b0, 1'b0, 64'h0);
      #1;
      total++;
      if (snap !== {1'b1, 2'd2, 4'b0100, 1'b1, 1'b1, 3'd3} || out_data !== 64'hC2) begin
         bad++; $display("FAIL lock_release got %h want %h", snap, {1'b1, 2'd2, 4'b0100, 5'b11011});
      end
      step();
      clear_reqs();
      credit_return = 1'b1;
      #1;
      total++;
      if (credits_avail !== 3'd2) begin
         bad++; $display("FAIL lock_credits got %0d want 2", credits_avail);
      end
      step(); step();
      credit_return = 1'b0;
      #1;
      total++;
      if (credits_avail !== 3'd4) begin
         bad++; $display("FAIL lock_refill got %0d want 4", credits_avail);
      end
   endtask

   task automatic test_credit_exhaust();
      bit           ev[7] = '{1, 1, 0, 0, 0, 1, 0};
      int           es[7] = '{0, 1, 0, 0, 0, 2, 0};
      logic [3:0]   er[7] = '{4'b0001, 4'b0010, 4'b0, 4'b0, 4'b0, 4'b0100, 4'b0};
      int           ec[7] = '{2, 1, 0, 0, 0, 1, 0};
      bit           cr[7] = '{0, 0, 0, 0, 1, 0, 0};
      step();
      b_req_valid = '1; b_req_sop = '1; b_req_eop = '1;
      for (int i = 0; i < N; i++) b_req_data[i*DW +: DW] = 64'hD0 + 64'(i);
      b_out_ready = 1'b1;
      for (int c = 0; c < 7; c++) begin
         b_credit_return = cr[c];
         #1;
         total++;
         if (b_snap !== {ev[c], er[c], 2'(ec[c])} ||
             (ev[c] && b_out_sel !== 2'(es[c]))) begin
            bad++; $display("FAIL exhaust[%0d] got %h sel %0d want %h sel %0d", c, b_snap,
                            b_out_sel, {ev[c], er[c], 2'(ec[c])}, es[c]);
         end
         step();
      end
      b_req_valid = '0; b_req_sop = '0; b_req_eop = '0;
      b_credit_return = 1'b0;
   endtask

   task automatic test_lock_ignores_credits();
      // rr_ptr is 3: req3 single beats spend three credits.
      set_req(3, 1'b1, 1'b1, 1'b1, 64'hE3);
      for (int k = 0; k < 3; k++) begin
         #1;
         total++;
         if (snap !== {1'b1, 2'd3, 4'b1000, 1'b1, 1'b1, 3'(4 - k)}) begin
            bad++; $display("FAIL spend[%0d] got %h want %h", k, snap,
                            {1'b1, 2'd3, 4'b1000, 1'b1, 1'b1, 3'(4 - k)});
         end
         step();
      end
      set_req(3, 1'b0, 1'b0, 1'b0, 64'h0);
      set_req(2, 1'b1, 1'b1, 1'b1, 64'hF2);
      for (int k = 0; k < 3; k++) begin
         set_req(0, 1'b1, k == 0, k == 2, 64'hE0 + 64'(k));
         #1;
         total++;
         if (snap !== {1'b1, 2'd0, 4'b0001, k == 0, k == 2, 3'(k == 0 ? 1 : 0)}) begin
            bad++; $display("FAIL lock_nocred[%0d] got %h want %h", k, snap,
                            {1'b1, 2'd0, 4'b0001, k == 0, k == 2, 3'(k == 0 ? 1 : 0)});
         end
         step();
      end
      set_req(0, 1'b0, 1'b0, 1'b0, 64'h0);
      #1;
      total++;
      if (snap_s !== {1'b0, 4'b0000, 3'd0}) begin
         bad++; $display("FAIL gate_after_lock got %h want %h", snap_s, {1'b0, 4'b0000, 3'd0});
      end
      step();
      clear_reqs();
      credit_return = 1'b1;
      step(); step(); step(); step();
      credit_return = 1'b0;
      #1;
      total++;
      if (credits_avail !== 3'd4) begin
         bad++; $display("FAIL refill4 got %0d want 4", credits_avail);
      end
   endtask

   task automatic test_backpressure();
      // rr_ptr is 1: req2 alone holds under backpressure.
      set_req(2, 1'b1, 1'b1, 1'b1, 64'h77);
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         total++;
         if (snap !== {1'b1, 2'd2, 4'b0000, 1'b1, 1'b1, 3'd4} || out_data !== 64'h77) begin
            bad++; $display("FAIL stall[%0d] got %h want %h", k, snap,
                            {1'b1, 2'd2, 4'b0000, 5'b11100});
         end
         step();
      end
      out_ready = 1'b1;
      #1;
      total++;
      if (snap !== {1'b1, 2'd2, 4'b0100, 1'b1, 1'b1, 3'd4}) begin
         bad++; $display("FAIL stall_release got %h want %h", snap, {1'b1, 2'd2, 4'b0100, 5'b11100});
      end
      step();
      set_req(2, 1'b0, 1'b0, 1'b0, 64'h0);
      set_req(3, 1'b1, 1'b1, 1'b1, 64'h88);
      credit_return = 1'b1;
      #1;
      total++;
      if (snap !== {1'b1, 2'd3, 4'b1000, 1'b1, 1'b1, 3'd3}) begin
         bad++; $display("FAIL simul_pre got %h want %h", snap, {1'b1, 2'd3, 4'b1000, 5'b11011});
      end
      step();
      clear_reqs();
      credit_return = 1'b0;
      #1;
      total++;
      if (credits_avail !== 3'd3) begin
         bad++; $display("FAIL simul_net got %0d want 3", credits_avail);
      end
      credit_return = 1'b1;
      step();
      credit_return = 1'b0;
   endtask

   task automatic test_reset_mid_packet();
      // rr_ptr is 0: req2 single beat moves it to 3, then req1 locks.
      set_req(2, 1'b1, 1'b1, 1'b1, 64'h21);
      step();
      set_req(2, 1'b0, 1'b0, 1'b0, 64'h0);
      set_req(1, 1'b1, 1'b1, 1'b0, 64'h11);
      #1;
      total++;
      if (snap !== {1'b1, 2'd1, 4'b0010, 1'b1, 1'b0, 3'd3}) begin
         bad++; $display("FAIL mid_beat1 got %h want %h", snap, {1'b1, 2'd1, 4'b0010, 5'b10011});
      end
      step();
      reset = 1'b1;
      clear_reqs();
      set_req(0, 1'b1, 1'b1, 1'b1, 64'h01);
      set_req(3, 1'b1, 1'b1, 1'b1, 64'h31);
      step();
      reset = 1'b0;
      #1;
      total++;
      if (snap !== {1'b1, 2'd0, 4'b0001, 1'b1, 1'b1, 3'd4} || out_data !== 64'h01) begin
         bad++; $display("FAIL after_reset got %h want %h", snap, {1'b1, 2'd0, 4'b0001, 5'b11100});
      end
      step();
      #1;
      total++;
      if (snap !== {1'b1, 2'd3, 4'b1000, 1'b1, 1'b1, 3'd3}) begin
         bad++; $display("FAIL after_reset2 got %h want %h", snap, {1'b1, 2'd3, 4'b1000, 5'b11011});
      end
      step();
      clear_reqs();
   endtask

   task automatic test_random();
      int             left[N];
      bit             rv[N], rs[N], re[N];
      logic [DW-1:0]  rd[N];
      bit             m_lock;
      int             m_idx, m_rr, m_cred;
      bit             ev, found, fire;
      int             es, idx;
      logic [N-1:0]   erdy;
      reset = 1'b1;
      clear_reqs();
      out_ready = 1'b0;
      credit_return = 1'b0;
      step();
      reset = 1'b0;
      for (int i = 0; i < N; i++) begin
         left[i] = 0; rv[i] = 0; rs[i] = 0; re[i] = 0; rd[i] = '0;
      end
      m_lock = 0; m_idx = 0; m_rr = 0; m_cred = MC;
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!rv[i] && $urandom_range(0, 1) == 1) begin
               if (left[i] == 0) begin
                  left[i] = $urandom_range(1, 3);
                  rs[i] = 1;
               end else begin
                  rs[i] = 0;
               end
               re[i] = (left[i] == 1);
               rv[i] = 1;
               rd[i] = {$urandom, $urandom};
            end
            set_req(i, rv[i], rs[i], re[i], rd[i]);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         credit_return = (m_cred < MC) && ($urandom_range(0, 2) == 0);
         // Reference: owner if mid-instruction, else first sop requester from rr.
         ev = 0; es = 0; erdy = '0;
         if (m_lock) begin
            es = m_idx;
            ev = rv[es];
            erdy[es] = out_ready;
         end else begin
            found = 0;
            for (int k = 0; k < N; k++) begin
               idx = (m_rr + k) % N;
               if (!found && rv[idx] && rs[idx]) begin
                  found = 1;
                  es = idx;
               end
            end
            ev = found && (m_cred > 0);
            if (ev) erdy[es] = out_ready;
         end
         #1;
         total++;
         if (snap_s !== {ev, erdy, 3'(m_cred)}) begin
            bad++; $display("FAIL random[%0d] valid/ready/credits got %h want %h", c, snap_s,
                            {ev, erdy, 3'(m_cred)});
         end
         if (ev) begin
            total++;
            if ({out_sel, out_sop, out_eop, out_data} !== {2'(es), rs[es], re[es], rd[es]}) begin
               bad++; $display("FAIL random[%0d] beat got sel %0d data %h want sel %0d data %h",
                               c, out_sel, out_data, es, rd[es]);
            end
         end
         fire = ev && out_ready;
         if (fire) begin
            rv[es] = 0;
            left[es]--;
            if (rs[es]) m_cred--;
            if (!m_lock && !re[es]) begin
               m_lock = 1;
               m_idx = es;
            end else if (m_lock && re[es]) begin
               m_lock = 0;
            end
            if (re[es]) m_rr = (es + 1) % N;
         end
         if (credit_return) m_cred++;
         step();
      end
      clear_reqs();
      credit_return = 1'b0;
   endtask

   initial begin
      total = 0;
      bad = 0;
      test_reset();
      test_contention();
      test_lock();
      test_credit_exhaust();
      test_lock_ignores_credits();
      test_backpressure();
      test_reset_mid_packet();
      test_random();
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
